// File: rtl/synapse_sched.sv
// synapse_sched: sequencer in front of one synapse array instance.
//
// Runs two kinds of pass on the array:
//   - weight reset: one-cycle o_wegt_rst, then wait for i_syn_done.
//   - timestep: latch the 576-bit spike vector, pulse o_run, stream 432
//     24-bit bundles (18 rows x 24 bundles) in step with the array's
//     1-cycle BRAM read, and collect the 18 returned currents, each tagged
//     with its neuron index.
// Every pass ends with a one-cycle o_done, or with a one-cycle o_err on
// overflow (a 19th current) or timeout.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   i_start, i_spike_vec  timestep request and its spike vector (IDLE only)
//   i_wegt_rst            weight-reset request (IDLE only, wins over i_start)
//   o_run, o_wegt_rst     one-cycle issue pulses to the array
//   o_spike_bundle/valid  bundle stream to the array
//   i_syn_current/valid   currents returned by the array
//   i_syn_done            array done pulse
//   o_current/neuron_idx/valid  registered current and its neuron index
//   o_busy, o_done, o_err status
module synapse_sched #(
  parameter int N_BUNDLE = 24,
  parameter int N_NEURON = 18,
  parameter int TIMEOUT  = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [575:0] i_spike_vec,
  input  logic         i_wegt_rst,
  output logic         o_run,
  output logic         o_wegt_rst,
  output logic [23:0]  o_spike_bundle,
  output logic         o_spike_valid,
  input  logic [24:0]  i_syn_current,
  input  logic         i_syn_valid,
  input  logic         i_syn_done,
  output logic [24:0]  o_current,
  output logic [4:0]   o_neuron_idx,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int VEC_W    = 576;
  localparam int BUNDLE_W = VEC_W / N_BUNDLE;
  localparam int FEED_LEN = N_BUNDLE * N_NEURON;
  localparam int NW       = $clog2(FEED_LEN + 1);
  localparam int BW       = $clog2(N_BUNDLE);
  localparam int TW       = $clog2(TIMEOUT + 1);

  localparam logic [NW-1:0] N_END  = NW'(FEED_LEN);
  localparam logic [BW-1:0] B_LAST = BW'(N_BUNDLE - 1);
  localparam logic [4:0]    C_FULL = 5'(N_NEURON);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RST_ISSUE, RST_WAIT, RUN_ISSUE, RUN_FEED, RUN_WAIT, DONE, ERR
  } state_t;

  state_t                            state;
  logic [N_BUNDLE-1:0][BUNDLE_W-1:0] spike_buf;
  logic [NW-1:0]                     n;          // bundles issued so far
  logic [BW-1:0]                     b;          // n mod N_BUNDLE
  logic [4:0]                        c;          // currents captured
  logic                              done_seen;
  logic [TW-1:0]                     tcnt;       // cycles since the issue pulse

  logic timeout_hit, overflow;
  // tcnt is 0 in the issue cycle, so hitting TIMEOUT-1 puts o_err exactly
  // TIMEOUT cycles after the issue pulse.
  assign timeout_hit = (tcnt == T_LAST);
  assign overflow    = i_syn_valid && (c == C_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      spike_buf      <= '0;
      n              <= '0;
      b              <= '0;
      c              <= '0;
      done_seen      <= 1'b0;
      tcnt           <= '0;
      o_run          <= 1'b0;
      o_wegt_rst     <= 1'b0;
      o_spike_bundle <= '0;
      o_spike_valid  <= 1'b0;
      o_current      <= '0;
      o_neuron_idx   <= '0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      // pulses and the current register default low/zero each cycle
      o_run        <= 1'b0;
      o_wegt_rst   <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_valid      <= 1'b0;
      o_current    <= '0;
      o_neuron_idx <= '0;
      tcnt         <= tcnt + 1'b1;

      case (state)
        IDLE: begin
          tcnt <= '0;
          if (i_wegt_rst) begin
            state      <= RST_ISSUE;
            o_wegt_rst <= 1'b1;
            o_busy     <= 1'b1;
          end else if (i_start) begin
            state     <= RUN_ISSUE;
            o_run     <= 1'b1;
            o_busy    <= 1'b1;
            spike_buf <= i_spike_vec;
          end
        end

        RST_ISSUE: state <= RST_WAIT;

        RST_WAIT: begin
          if (i_syn_done) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else if (timeout_hit) begin
            state <= ERR;
            o_err <= 1'b1;
          end
        end

        RUN_ISSUE: begin
          n         <= '0;
          b         <= '0;
          c         <= '0;
          done_seen <= 1'b0;
          state     <= RUN_FEED;
        end

        RUN_FEED, RUN_WAIT: begin
          if (i_syn_done) done_seen <= 1'b1;
          if (overflow || timeout_hit) begin
            state          <= ERR;
            o_err          <= 1'b1;
            o_spike_valid  <= 1'b0;
            o_spike_bundle <= '0;
          end else begin
            if (i_syn_valid) begin
              o_valid      <= 1'b1;
              o_current    <= i_syn_current;
              o_neuron_idx <= c;
              c            <= c + 1'b1;
            end
            if (state == RUN_FEED) begin
              // first cycle here is the idle slot; bundle n lands at T+2+n
              if (n == N_END) begin
                o_spike_valid  <= 1'b0;
                o_spike_bundle <= '0;
                state          <= RUN_WAIT;
              end else begin
                o_spike_valid  <= 1'b1;
                o_spike_bundle <= spike_buf[b];
                n              <= n + 1'b1;
                b              <= (b == B_LAST) ? '0 : b + 1'b1;
              end
            end else if (done_seen && c == C_FULL) begin
              // done may precede the last current; wait for both
              state  <= DONE;
              o_done <= 1'b1;
            end
          end
        end

        DONE, ERR: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_sched.sv
// Bench for synapse_sched. A per-cycle expectation timeline is built from
// the block's timing rules (o_run at T, bundle n at T+2+n, currents at the
// cycle after they arrive, done/err/busy windows) and compared against the
// DUT every cycle. A small array model returns popcount*weight currents for
// each row of 24 bundles; scripted arrays drive the odd cases.
module tb_synapse_sched;
  localparam int TO    = 500;
  localparam int DEPTH = 8192;
  localparam int B_BUSY = 0, B_ERR = 1, B_DONE = 2, B_WRST = 3, B_RUN = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_start, i_wegt_rst;
  logic [575:0] i_spike_vec;
  logic         o_run, o_wegt_rst;
  logic [23:0]  o_spike_bundle;
  logic         o_spike_valid;
  logic [24:0]  i_syn_current;
  logic         i_syn_valid, i_syn_done;
  logic [24:0]  o_current;
  logic [4:0]   o_neuron_idx;
  logic         o_valid, o_busy, o_done, o_err;

  synapse_sched #(.N_BUNDLE(24), .N_NEURON(18), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_spike_vec(i_spike_vec),
    .i_wegt_rst(i_wegt_rst), .o_run(o_run), .o_wegt_rst(o_wegt_rst),
    .o_spike_bundle(o_spike_bundle), .o_spike_valid(o_spike_valid),
    .i_syn_current(i_syn_current), .i_syn_valid(i_syn_valid), .i_syn_done(i_syn_done),
    .o_current(o_current), .o_neuron_idx(o_neuron_idx), .o_valid(o_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outputs per cycle
  logic [4:0]  e_ctl [DEPTH];   // {run, wegt_rst, done, err, busy}
  logic [24:0] e_spk [DEPTH];   // {valid, bundle}
  logic [30:0] e_cur [DEPTH];   // {valid, idx, current}
  bit          chk   [DEPTH];
  // scripted array responses per cycle
  logic        s_valid [DEPTH];
  logic        s_done  [DEPTH];
  logic [24:0] s_cur   [DEPTH];

  int n_assert = 0, n_fail = 0;
  int mon_spk = 0, mon_val = 0, mon_run = 0, mon_done_cyc = 0, mon_err_cyc = 0;
  int mon_last_cur = 0;

  bit auto_en;
  int wgt [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic exp_idle(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      chk[i] = 1'b1; e_ctl[i] = '0; e_spk[i] = '0; e_cur[i] = '0;
    end
  endtask

  task automatic exp_busy(input int a, input int b);
    for (int i = a; i <= b; i++) e_ctl[i][B_BUSY] = 1'b1;
  endtask

  task automatic exp_feed(input int t0, input logic [575:0] v);
    for (int n = 0; n < 432; n++) e_spk[t0 + 2 + n] = {1'b1, v[(n % 24) * 24 +: 24]};
  endtask

  task automatic exp_cur(input int c, input int idx, input logic [24:0] val);
    e_cur[c] = {1'b1, 5'(idx), val};
  endtask

  // full timestep with the array model answering: every neuron sees the
  // whole vector once, so its current is weight * popcount(vector)
  task automatic exp_nominal(input int t0, input logic [575:0] v);
    int pc;
    pc = $countones(v);
    exp_idle(t0 - 1, t0 + 440);
    e_ctl[t0][B_RUN] = 1'b1;
    exp_busy(t0, t0 + 436);
    exp_feed(t0, v);
    for (int k = 0; k < 18; k++) exp_cur(t0 + 27 + 24 * k, k, 25'(wgt[k] * pc));
    e_ctl[t0 + 436][B_DONE] = 1'b1;
  endtask

  task automatic issue(input logic st, input logic wr, input logic [575:0] v);
    i_start = st; i_wegt_rst = wr; i_spike_vec = v;
    tick(1);
    i_start = 1'b0; i_wegt_rst = 1'b0; i_spike_vec = ~v;
  endtask

  function automatic logic [24:0] dval(input int k);
    return (k == 17) ? 25'h1FFFFFF : 25'(k * 1234567 + 17);
  endfunction

  // array model: 1-cycle read latency, current of a row one cycle after
  // its 24th bundle, done in the cycle of the 432nd bundle
  int          a_cnt = 0, a_row = 0, a_acc = 0;
  logic        a_pend = 1'b0;
  logic [24:0] a_pval = '0;
  logic        av, ad;
  logic [24:0] ac;
  initial begin
    i_syn_valid = 1'b0; i_syn_current = '0; i_syn_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      av = 1'b0; ad = 1'b0; ac = '0;
      if (!reset_n || o_run) begin
        a_cnt = 0; a_row = 0; a_acc = 0; a_pend = 1'b0;
      end else begin
        if (a_pend) begin av = 1'b1; ac = a_pval; a_pend = 1'b0; end
        if (o_spike_valid) begin
          a_acc += $countones(o_spike_bundle);
          a_cnt++;
          if (a_cnt % 24 == 0 && a_row < 18) begin
            a_pend = 1'b1; a_pval = 25'(a_acc * wgt[a_row]); a_acc = 0; a_row++;
          end
          if (a_cnt == 432) ad = 1'b1;
        end
      end
      i_syn_valid   = (auto_en && av) || s_valid[cyc];
      i_syn_current = (auto_en && av) ? ac : s_cur[cyc];
      i_syn_done    = (auto_en && ad) || s_done[cyc];
    end
  end

  // per-cycle compare against the timeline
  initial begin
    forever begin
      @(negedge clk);
      if (o_spike_valid === 1'b1) mon_spk++;
      if (o_run === 1'b1) mon_run++;
      if (o_valid === 1'b1) begin mon_val++; mon_last_cur = int'(o_current); end
      if (o_done === 1'b1) mon_done_cyc = cyc;
      if (o_err === 1'b1) mon_err_cyc = cyc;
      if (cyc < DEPTH && chk[cyc]) begin
        check("ctl{run,wrst,done,err,busy}", 64'({o_run, o_wegt_rst, o_done, o_err, o_busy}), 64'(e_ctl[cyc]));
        check("spike{valid,bundle}", 64'({o_spike_valid, o_spike_bundle}), 64'(e_spk[cyc]));
        check("cur{valid,idx,current}", 64'({o_valid, o_neuron_idx, o_current}), 64'(e_cur[cyc]));
      end
    end
  end

  initial begin
    int t0, s0, v0, r0;
    logic [575:0] vd, vh;
    for (int i = 0; i < DEPTH; i++) begin
      chk[i] = 1'b0; e_ctl[i] = '0; e_spk[i] = '0; e_cur[i] = '0;
      s_valid[i] = 1'b0; s_done[i] = 1'b0; s_cur[i] = '0;
    end
    for (int k = 0; k < 18; k++) wgt[k] = 1;
    reset_n = 1'b0; i_start = 1'b0; i_wegt_rst = 1'b0; i_spike_vec = '0; auto_en = 1'b0;

    // reset state
    exp_idle(1, 8);
    tick(4);
    reset_n = 1'b1;
    go_to(8);

    // A: all-ones timestep, weights 1
    auto_en = 1'b1;
    t0 = cyc + 1; exp_nominal(t0, '1);
    s0 = mon_spk; v0 = mon_val;
    issue(1'b1, 1'b0, '1);
    go_to(t0 + 441);
    check_int("a_spike_cycles", mon_spk - s0, 432);
    check_int("a_current_pulses", mon_val - v0, 18);
    check_int("a_done_offset", mon_done_cyc - t0, 436);
    check_int("a_last_current", mon_last_cur, 576);

    // B: weight reset, done at T+433
    t0 = cyc + 1;
    exp_idle(t0 - 1, t0 + 440);
    e_ctl[t0][B_WRST] = 1'b1; exp_busy(t0, t0 + 434); e_ctl[t0 + 434][B_DONE] = 1'b1;
    s_done[t0 + 433] = 1'b1;
    issue(1'b0, 1'b1, '1);
    go_to(t0 + 441);
    check_int("b_done_offset", mon_done_cyc - t0, 434);

    // C: start and weight reset together; only the reset runs
    t0 = cyc + 1;
    exp_idle(t0 - 1, t0 + 50);
    e_ctl[t0][B_WRST] = 1'b1; exp_busy(t0, t0 + 41); e_ctl[t0 + 41][B_DONE] = 1'b1;
    s_done[t0 + 40] = 1'b1;
    r0 = mon_run;
    issue(1'b1, 1'b1, '1);
    go_to(t0 + 51);
    check_int("c_run_pulses", mon_run - r0, 0);

    // D: done early, 18th current late -> done one cycle after last o_valid
    auto_en = 1'b0;
    for (int b = 0; b < 24; b++) vd[b * 24 +: 24] = 24'($urandom);
    t0 = cyc + 1;
    exp_idle(t0 - 1, t0 + 460);
    e_ctl[t0][B_RUN] = 1'b1; exp_busy(t0, t0 + 452); exp_feed(t0, vd);
    s_done[t0 + 200] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_valid[t0 + 26 + 24 * k] = 1'b1; s_cur[t0 + 26 + 24 * k] = dval(k);
      exp_cur(t0 + 27 + 24 * k, k, dval(k));
    end
    s_valid[t0 + 450] = 1'b1; s_cur[t0 + 450] = dval(17);
    exp_cur(t0 + 451, 17, dval(17));
    e_ctl[t0 + 452][B_DONE] = 1'b1;
    issue(1'b1, 1'b0, vd);
    go_to(t0 + 461);
    check_int("d_done_offset", mon_done_cyc - t0, 452);

    // E: a 19th current right after the 18th -> error, no done
    t0 = cyc + 1;
    exp_idle(t0 - 1, t0 + 460);
    e_ctl[t0][B_RUN] = 1'b1; exp_busy(t0, t0 + 452); exp_feed(t0, vd);
    s_done[t0 + 200] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      s_valid[t0 + 26 + 24 * k] = 1'b1; s_cur[t0 + 26 + 24 * k] = dval(k);
      exp_cur(t0 + 27 + 24 * k, k, dval(k));
    end
    s_valid[t0 + 450] = 1'b1; s_cur[t0 + 450] = dval(17);
    exp_cur(t0 + 451, 17, dval(17));
    s_valid[t0 + 451] = 1'b1; s_cur[t0 + 451] = 25'h0ABCDE;
    e_ctl[t0 + 452][B_ERR] = 1'b1;
    issue(1'b1, 1'b0, vd);
    go_to(t0 + 461);
    check_int("e_err_offset", mon_err_cyc - t0, 452);
    check_int("e_no_done", int'(mon_done_cyc > t0), 0);

    // F: array silent -> timeout error at issue+TIMEOUT
    t0 = cyc + 1;
    exp_idle(t0 - 1, t0 + 505);
    e_ctl[t0][B_RUN] = 1'b1; exp_busy(t0, t0 + 500); exp_feed(t0, '1);
    e_ctl[t0 + 500][B_ERR] = 1'b1;
    issue(1'b1, 1'b0, '1);
    go_to(t0 + 506);
    check_int("f_err_offset", mon_err_cyc - t0, 500);

    // G: reset at T+100 -> everything zero next cycle, no done/err
    auto_en = 1'b1;
    t0 = cyc + 1; exp_nominal(t0, '1);
    exp_idle(t0 + 101, t0 + 111);
    issue(1'b1, 1'b0, '1);
    go_to(t0 + 100);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    go_to(t0 + 112);
    check_int("g_no_done", int'(mon_done_cyc > t0), 0);
    check_int("g_no_err", int'(mon_err_cyc > t0), 0);

    // H: one hot bit per bundle at distinct positions, weights k+1
    for (int k = 0; k < 18; k++) wgt[k] = k + 1;
    for (int b = 0; b < 24; b++) vh[b * 24 +: 24] = 24'd1 << b;
    t0 = cyc + 1; exp_nominal(t0, vh);
    v0 = mon_val;
    issue(1'b1, 1'b0, vh);
    go_to(t0 + 441);
    check_int("h_current_pulses", mon_val - v0, 18);
    check_int("h_last_current", mon_last_cur, 432);
    check_int("h_done_offset", mon_done_cyc - t0, 436);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
